// File: rtl/alu_functional_unit_pkg.sv
// Shared types, widths and the ALU datapath function for the ALU functional unit.
package alu_functional_unit_pkg;

    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned OPC_W  = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_ADDI = 4'd7,
        OP_LUI  = 4'd8,
        OP_SLT  = 4'd9
    } opcode_e;

    // Opcode kept raw so unassigned encodings 10-15 can flow through the pipeline.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  tag;
        logic [IMM_W-1:0]  imm;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
    } issue_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
    } cdb_entry_t;

    function automatic logic [DATA_W-1:0] alu_compute(input issue_t op);
        logic [DATA_W-1:0] res;
        res = '0;
        case (op.opcode)
            OP_ADD:  res = op.val1 + op.val2;
            OP_SUB:  res = op.val1 - op.val2;
            OP_AND:  res = op.val1 & op.val2;
            OP_OR:   res = op.val1 | op.val2;
            OP_XOR:  res = op.val1 ^ op.val2;
            OP_SHL:  res = op.val1 << op.val2[3:0];
            OP_SHR:  res = op.val1 >> op.val2[3:0];
            OP_ADDI: res = op.val1 + {{(DATA_W-IMM_W){op.imm[IMM_W-1]}}, op.imm};
            OP_LUI:  res = {op.imm, {(DATA_W-IMM_W){1'b0}}};
            OP_SLT:  res = DATA_W'($signed(op.val1) < $signed(op.val2));
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_functional_unit_result_fifo.sv
// FIFO-ordered result buffer; head is presented combinationally, push and pop may share an edge.
module result_fifo
    import alu_functional_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  cdb_entry_t                    i_data,
    input  logic                          i_pop,
    output cdb_entry_t                    o_head_c,
    output logic                          o_full_c,
    output logic                          o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // A full buffer still accepts a push when the head leaves on the same edge.
    assign w_do_pop  = i_pop && !o_empty_c && !i_flush;
    assign w_do_push = i_push && (!o_full_c || w_do_pop) && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_functional_unit.sv
// Two-stage ALU pipeline feeding a result buffer that drives the common data bus.
module alu_functional_unit
    import alu_functional_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_rob_index,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [IMM_W-1:0]  in_i,
    input  logic [DATA_W-1:0] in_val1,
    input  logic [DATA_W-1:0] in_val2,
    output logic              busy,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_rob_index,
    output logic [DATA_W-1:0] cdb_result,
    input  logic              cdb_grant,
    output logic              overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(DEPTH + 3);

    if (LAT != 2) begin : g_bad_lat
        $error("alu_functional_unit: LAT must be 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_functional_unit: DEPTH must be a power of two >= 2");
    end

    logic             r_s1_valid;
    issue_t           r_s1_op;
    logic             r_s2_valid;
    cdb_entry_t       r_s2_entry;
    logic             r_overflow;
    logic             w_issue;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occ;
    cdb_entry_t       w_head;

    // Counting every op in flight reserves a buffer slot before the op is accepted.
    assign w_occ   = OCC_W'(w_count) + OCC_W'(r_s1_valid) + OCC_W'(r_s2_valid);
    assign busy    = (w_occ >= OCC_W'(DEPTH - 1));
    assign w_issue = in_valid && !busy && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_s1_valid <= w_issue;
            r_s2_valid <= r_s1_valid && !flush;
            if (in_valid && busy) r_overflow <= 1'b1;
        end
    end

    // Payload registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_s1_op <= '{opcode: in_opcode, tag: in_rob_index, imm: in_i,
                         val1: in_val1, val2: in_val2};
        end
        if (r_s1_valid) begin
            r_s2_entry <= '{tag: r_s1_op.tag, result: alu_compute(r_s1_op)};
        end
    end

    result_fifo #(.DEPTH(DEPTH)) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_push    (r_s2_valid),
        .i_data    (r_s2_entry),
        .i_pop     (cdb_grant),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    assign cdb_valid     = !w_empty;
    assign cdb_rob_index = w_head.tag;
    assign cdb_result    = w_head.result;
    assign overflow      = r_overflow;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Directed self-checking bench for alu_functional_unit: opcode table plus pipeline/buffer corner sequences.
module tb_alu_functional_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_rob_index;
    logic [3:0]  in_opcode;
    logic [7:0]  in_i;
    logic [15:0] in_val1;
    logic [15:0] in_val2;
    logic        busy;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_index;
    logic [15:0] cdb_result;
    logic        cdb_grant;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu_functional_unit #(.DEPTH(4), .LAT(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_rob_index  (in_rob_index),
        .in_opcode     (in_opcode),
        .in_i          (in_i),
        .in_val1       (in_val1),
        .in_val2       (in_val2),
        .busy          (busy),
        .cdb_valid     (cdb_valid),
        .cdb_rob_index (cdb_rob_index),
        .cdb_result    (cdb_result),
        .cdb_grant     (cdb_grant),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic [7:0]  imm;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [3:0]  tag;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] opc, input logic [7:0] imm,
                             input logic [15:0] v1, input logic [15:0] v2, input logic [3:0] tag);
        in_valid     = 1'b1;
        in_opcode    = opc;
        in_i         = imm;
        in_val1      = v1;
        in_val2      = v2;
        in_rob_index = tag;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_opcode = '0; in_i = '0; in_val1 = '0; in_val2 = '0; in_rob_index = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [15:0] exp_q [$];
    logic [3:0]  tag_q [$];
    int          issued;

    initial begin
        vecs[0]  = '{4'd0,  8'h00, 16'h7FFF, 16'h0001, 4'd3,  16'h8000};
        vecs[1]  = '{4'd0,  8'h00, 16'hFFFF, 16'h0002, 4'd5,  16'h0001};
        vecs[2]  = '{4'd1,  8'h00, 16'h0005, 16'h0007, 4'd1,  16'hFFFE};
        vecs[3]  = '{4'd2,  8'h00, 16'hF0F0, 16'h3CCC, 4'd6,  16'h30C0};
        vecs[4]  = '{4'd3,  8'h00, 16'hF0F0, 16'h0F01, 4'd7,  16'hFFF1};
        vecs[5]  = '{4'd4,  8'h00, 16'hAAAA, 16'hFFFF, 4'd8,  16'h5555};
        vecs[6]  = '{4'd5,  8'h00, 16'h0001, 16'h0013, 4'd9,  16'h0008};
        vecs[7]  = '{4'd5,  8'h00, 16'h8001, 16'h000F, 4'd10, 16'h8000};
        vecs[8]  = '{4'd6,  8'h00, 16'h8000, 16'h0004, 4'd11, 16'h0800};
        vecs[9]  = '{4'd7,  8'hFE, 16'h000A, 16'h0000, 4'd2,  16'h0008};
        vecs[10] = '{4'd7,  8'h7F, 16'h0001, 16'h0000, 4'd12, 16'h0080};
        vecs[11] = '{4'd8,  8'hAB, 16'h1234, 16'h5678, 4'd13, 16'hAB00};
        vecs[12] = '{4'd9,  8'h00, 16'hFFFF, 16'h0001, 4'd4,  16'h0001};
        vecs[13] = '{4'd9,  8'h00, 16'h0001, 16'hFFFF, 4'd14, 16'h0000};
        vecs[14] = '{4'd9,  8'h00, 16'h8000, 16'h7FFF, 4'd15, 16'h0001};
        vecs[15] = '{4'd10, 8'h55, 16'h1234, 16'h5678, 4'd0,  16'h0000};
        vecs[16] = '{4'd15, 8'hFF, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0000};

        do_reset();
        check("reset_cdb_valid", 32'(cdb_valid), 0);
        check("reset_busy",      32'(busy),      0);
        check("reset_overflow",  32'(overflow),  0);

        // One op at a time, grant tied high: valid exactly after edge k+2, one cycle wide.
        cdb_grant = 1'b1;
        for (int v = 0; v < 17; v++) begin
            set_issue(vecs[v].opc, vecs[v].imm, vecs[v].v1, vecs[v].v2, vecs[v].tag);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_early", v), 32'(cdb_valid), 0);
            tick();
            check($sformatf("vec%0d_early2", v), 32'(cdb_valid), 0);
            tick();
            check($sformatf("vec%0d_valid", v),  32'(cdb_valid), 1);
            check($sformatf("vec%0d_tag", v),    32'(cdb_rob_index), 32'(vecs[v].tag));
            check($sformatf("vec%0d_result", v), 32'(cdb_result), 32'(vecs[v].exp));
            tick();
            check($sformatf("vec%0d_width", v),  32'(cdb_valid), 0);
        end

        // Back-to-back issue: SUB, ADDI, SLT results on consecutive cycles.
        set_issue(4'd1, 8'h00, 16'd5, 16'd7, 4'd1);            tick();
        set_issue(4'd7, 8'hFE, 16'd10, 16'd0, 4'd2);           tick();
        set_issue(4'd9, 8'h00, 16'hFFFF, 16'h0001, 4'd4);      tick();
        in_valid = 1'b0;
        check("b2b_r0_valid", 32'(cdb_valid), 1);
        check("b2b_r0", {12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'hFFFE});
        tick();
        check("b2b_r1", {15'h0, cdb_valid, 12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'h2, 16'h0008});
        tick();
        check("b2b_r2", {15'h0, cdb_valid, 12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'h4, 16'h0001});
        tick();
        check("b2b_drained", 32'(cdb_valid), 0);

        // Grant held low: busy after three outstanding ops, then a dropped issue sets overflow.
        cdb_grant = 1'b0;
        set_issue(4'd0, 8'h00, 16'h0100, 16'h0001, 4'd6);      tick();
        check("fill_busy1", 32'(busy), 0);
        set_issue(4'd0, 8'h00, 16'h0200, 16'h0002, 4'd7);      tick();
        check("fill_busy2", 32'(busy), 0);
        set_issue(4'd0, 8'h00, 16'h0300, 16'h0003, 4'd8);      tick();
        in_valid = 1'b0;
        check("fill_busy3", 32'(busy), 1);
        check("fill_no_overflow", 32'(overflow), 0);
        repeat (2) tick();
        check("full_busy", 32'(busy), 1);
        set_issue(4'd0, 8'h00, 16'h0400, 16'h0004, 4'd9);      tick();
        in_valid = 1'b0;
        check("drop_overflow", 32'(overflow), 1);
        repeat (3) tick();
        check("drop_head_intact", {12'h0, cdb_rob_index, cdb_result}, {16'h6, 16'h0101});
        cdb_grant = 1'b1;
        tick();
        check("drain_r1", {15'h0, cdb_valid, 12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'h7, 16'h0202});
        check("drain_busy_fall", 32'(busy), 0);
        tick();
        check("drain_r2", {15'h0, cdb_valid, 12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'h8, 16'h0303});
        tick();
        check("drain_no_extra", 32'(cdb_valid), 0);
        repeat (3) tick();
        check("drain_no_extra_late", 32'(cdb_valid), 0);
        check("overflow_sticky", 32'(overflow), 1);

        // Streaming with gapped grant: simultaneous push/pop and pointer wrap, FIFO order kept.
        do_reset();
        issued = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            cdb_grant = ((cyc % 3) != 0);
            if (!busy && issued < 10) begin
                set_issue(4'd7, 8'h01, 16'h0100 + 16'(issued), 16'h0000, 4'(issued));
                exp_q.push_back(16'h0101 + 16'(issued));
                tag_q.push_back(4'(issued));
                issued++;
            end else begin
                in_valid = 1'b0;
            end
            if (cdb_valid && cdb_grant) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_result", 32'(cdb_valid), 0);
                end else begin
                    check($sformatf("stream_pop_%0d", tag_q[0]),
                          {12'h0, cdb_rob_index, cdb_result}, {12'h0, tag_q[0], exp_q[0]});
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                end
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_issued", 32'(issued), 10);
        check("stream_all_popped", 32'(exp_q.size()), 0);
        check("stream_overflow", 32'(overflow), 0);

        // Flush with two ops in flight and one buffered; same-cycle issue dropped.
        do_reset();
        set_issue(4'd0, 8'h00, 16'd1, 16'd1, 4'd1);            tick();
        set_issue(4'd0, 8'h00, 16'd2, 16'd2, 4'd2);            tick();
        set_issue(4'd0, 8'h00, 16'd3, 16'd3, 4'd3);            tick();
        check("flush_pre_valid", 32'(cdb_valid), 1);
        flush = 1'b1;
        set_issue(4'd0, 8'h00, 16'd4, 16'd4, 4'd9);            tick();
        flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b1;
        check("flush_cdb_low", 32'(cdb_valid), 0);
        check("flush_busy_low", 32'(busy), 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("flush_no_stale_%0d", c), 32'(cdb_valid), 0);
        end
        set_issue(4'd1, 8'h00, 16'd20, 16'd5, 4'd6);           tick();
        in_valid = 1'b0;
        tick(); tick();
        check("flush_recover", {15'h0, cdb_valid, 12'h0, cdb_rob_index, cdb_result}, {16'h1, 16'h6, 16'h000F});

        // Async reset pulse mid-stream, with overflow previously set.
        cdb_grant = 1'b0;
        tick();
        set_issue(4'd0, 8'h00, 16'd1, 16'd1, 4'd1);            tick();
        set_issue(4'd0, 8'h00, 16'd2, 16'd2, 4'd2);            tick();
        set_issue(4'd0, 8'h00, 16'd3, 16'd3, 4'd3);            tick();
        in_valid = 1'b0;
        check("rst_pre_valid", 32'(cdb_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid",    32'(cdb_valid), 0);
        check("rst_async_busy",     32'(busy),      0);
        check("rst_async_overflow", 32'(overflow),  0);
        tick();
        rst_n = 1'b1; cdb_grant = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rst_no_stale_%0d", c), 32'(cdb_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
